// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : Interrupt controller for the fetch stage. Synchronises up to 32
//             asynchronous interrupt lines, latches them per channel in edge
//             or level mode, masks them, picks the lowest-numbered enabled
//             channel and holds a request to the pipeline under a
//             request / acknowledge / end-of-interrupt handshake. Software
//             reaches it through a 32-byte register window.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             irq_in            - asynchronous interrupt lines
//             irq, irq_id       - registered request and channel id
//             irq_ack           - one-cycle trap-taken pulse from fetch
//             w_addr/w_data/we  - register write port (byte address)
//             r_addr/r_data     - register read port, 1-cycle latency
//  Registers: 0x00 PENDING (R, W1C edge bits)  0x04 MASK (RW)
//             0x08 MODE (RW, 1 = edge)         0x0C ACTIVE (R)
//             0x10 EOI (W, any data)
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int          NUM_IRQ     = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq,
    output logic [4:0]         irq_id,
    input  logic               irq_ack,
    input  logic [31:0]        w_addr,
    input  logic [31:0]        w_data,
    input  logic               we,
    input  logic [31:0]        r_addr,
    output logic [31:0]        r_data
);

    // ------------------------------------------------------------------
    // Register offsets inside the window
    // ------------------------------------------------------------------
    localparam logic [4:0] c_OFF_PENDING = 5'h00;
    localparam logic [4:0] c_OFF_MASK    = 5'h04;
    localparam logic [4:0] c_OFF_MODE    = 5'h08;
    localparam logic [4:0] c_OFF_ACTIVE  = 5'h0C;
    localparam logic [4:0] c_OFF_EOI     = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q;          // last synchronised value, for edges
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q,    mask_d;
    logic [NUM_IRQ-1:0] mode_q,    mode_d;
    state_t             state_q;
    logic               irq_q;
    logic [4:0]         irq_id_q;
    logic               insvc_q;
    logic [4:0]         insvc_id_q;
    logic [31:0]        r_data_q, r_data_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] w_sync;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_wdata;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_ack_clr;
    logic [NUM_IRQ-1:0] w_enabled;
    logic               w_wr_hit;
    logic               w_rd_hit;
    logic               w_wr_pending;
    logic               w_wr_mask;
    logic               w_wr_mode;
    logic               w_wr_eoi;
    logic               w_ack_take;
    logic [4:0]         w_sel_id;
    logic               w_id_enabled;
    logic [31:0]        w_pending_word;
    logic [31:0]        w_mask_word;
    logic [31:0]        w_mode_word;
    logic               w_unused;

    assign irq    = irq_q;
    assign irq_id = irq_id_q;
    assign r_data = r_data_q;

    // Upper write-data bits beyond NUM_IRQ carry no storage.
    assign w_unused = ^{1'b0, w_data};

    // ------------------------------------------------------------------
    // Input synchroniser and edge detector
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign w_sync = sync_q[SYNC_STAGES-1];
    assign w_rise = w_sync & ~prev_q;

    // ------------------------------------------------------------------
    // Register window decode
    // ------------------------------------------------------------------
    assign w_wr_hit     = we && (w_addr[31:5] == BASE_ADDR[31:5]);
    assign w_rd_hit     = (r_addr[31:5] == BASE_ADDR[31:5]);
    assign w_wr_pending = w_wr_hit && (w_addr[4:0] == c_OFF_PENDING);
    assign w_wr_mask    = w_wr_hit && (w_addr[4:0] == c_OFF_MASK);
    assign w_wr_mode    = w_wr_hit && (w_addr[4:0] == c_OFF_MODE);
    assign w_wr_eoi     = w_wr_hit && (w_addr[4:0] == c_OFF_EOI);
    assign w_wdata      = w_data[NUM_IRQ-1:0];
    assign w_w1c        = w_wr_pending ? w_wdata : '0;

    // ------------------------------------------------------------------
    // Pending latch
    // ------------------------------------------------------------------
    assign w_ack_take = (state_q == ST_REQ) && irq_ack;

    // One-hot clear of the acknowledged channel.
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_ack_clr[i] = w_ack_take && (irq_id_q == 5'(i));
        end
    end

    // Edge bits: the set term is OR-ed in last so a new edge beats both a
    // software W1C and the acknowledge clear landing in the same cycle.
    // Level bits simply track the synchronised line.
    assign pending_d = (mode_q & ((pending_q & ~w_w1c & ~w_ack_clr) | w_rise))
                     | (~mode_q & w_sync);

    assign mask_d = w_wr_mask ? w_wdata : mask_q;
    assign mode_d = w_wr_mode ? w_wdata : mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Priority selection: lowest enabled index wins
    // ------------------------------------------------------------------
    assign w_enabled = pending_q & mask_q;

    always_comb begin
        w_sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_enabled[i]) begin
                w_sel_id = 5'(i);
            end
        end
    end

    // Is the channel currently being requested still enabled?
    always_comb begin
        w_id_enabled = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_id_q == 5'(i)) begin
                w_id_enabled = w_enabled[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request / acknowledge / EOI state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
            insvc_q    <= 1'b0;
            insvc_id_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    irq_q <= 1'b0;
                    if (|w_enabled) begin
                        irq_q    <= 1'b1;
                        irq_id_q <= w_sel_id;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Acknowledge is checked first so it beats a retraction
                    // arriving in the same cycle.
                    if (irq_ack) begin
                        irq_q      <= 1'b0;
                        insvc_q    <= 1'b1;
                        insvc_id_q <= irq_id_q;
                        state_q    <= ST_SERVICE;
                    end else if (!w_id_enabled) begin
                        irq_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    irq_q <= 1'b0;
                    if (w_wr_eoi) begin
                        insvc_q    <= 1'b0;
                        insvc_id_q <= '0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register read port. Reads see the pre-edge register contents, so a
    // write and read of the same register in one cycle return the old value.
    // ------------------------------------------------------------------
    always_comb begin
        w_pending_word                = '0;
        w_mask_word                   = '0;
        w_mode_word                   = '0;
        w_pending_word[NUM_IRQ-1:0]   = pending_q;
        w_mask_word[NUM_IRQ-1:0]      = mask_q;
        w_mode_word[NUM_IRQ-1:0]      = mode_q;
    end

    always_comb begin
        r_data_d = '0;
        if (w_rd_hit) begin
            case (r_addr[4:0])
                c_OFF_PENDING: r_data_d = w_pending_word;
                c_OFF_MASK:    r_data_d = w_mask_word;
                c_OFF_MODE:    r_data_d = w_mode_word;
                c_OFF_ACTIVE:  r_data_d = {insvc_q, 26'd0, insvc_id_q};
                default:       r_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= r_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Self-checking bench for irq_ctrl. Stimulus pushes expected
//             register reads and expected irq/irq_id observations into
//             scoreboard queues; a monitor on the falling edge pops and
//             compares whenever a read result or an observation is due.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam int          NUM_IRQ = 8;
    localparam logic [31:0] BASE    = 32'hFFFF_0000;
    localparam logic [31:0] A_PEND  = BASE + 32'h00;
    localparam logic [31:0] A_MASK  = BASE + 32'h04;
    localparam logic [31:0] A_MODE  = BASE + 32'h08;
    localparam logic [31:0] A_ACT   = BASE + 32'h0C;
    localparam logic [31:0] A_EOI   = BASE + 32'h10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_IRQ-1:0] irq_in = '0;
    logic               irq;
    logic [4:0]         irq_id;
    logic               irq_ack = 1'b0;
    logic [31:0]        w_addr = '0;
    logic [31:0]        w_data = '0;
    logic               we = 1'b0;
    logic [31:0]        r_addr = '0;
    logic [31:0]        r_data;

    irq_ctrl #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (2),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .irq     (irq),
        .irq_id  (irq_id),
        .irq_ack (irq_ack),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .we      (we),
        .r_addr  (r_addr),
        .r_data  (r_data)
    );

    always #5 clk = ~clk;

    // Scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd_exp_q  [$];
    string       rd_name_q [$];
    logic [5:0]  irq_exp_q [$];
    string       irq_name_q[$];
    logic        rd_req  = 1'b0;
    logic        rd_vld  = 1'b0;
    logic        chk_irq = 1'b0;
    logic [31:0] mon_rd_e;
    logic [5:0]  mon_irq_e;
    string       mon_name;

    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: read data is valid the cycle after the request; irq
    // observations are due in the cycle the stimulus flags them.
    always @(negedge clk) begin
        if (rd_vld) begin
            n_tests++;
            if (rd_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_orphan: r_data=%h but no expected value queued", r_data);
            end else begin
                mon_rd_e = rd_exp_q.pop_front();
                mon_name = rd_name_q.pop_front();
                if (r_data !== mon_rd_e) begin
                    n_fail++;
                    $display("FAIL %s: r_data=%h expected %h", mon_name, r_data, mon_rd_e);
                end
            end
        end
        if (chk_irq) begin
            n_tests++;
            if (irq_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL irq_orphan: irq=%b irq_id=%0d but nothing queued", irq, irq_id);
            end else begin
                mon_irq_e = irq_exp_q.pop_front();
                mon_name  = irq_name_q.pop_front();
                if ({irq, irq_id} !== mon_irq_e) begin
                    n_fail++;
                    $display("FAIL %s: irq=%b irq_id=%0d expected irq=%b irq_id=%0d",
                             mon_name, irq, irq_id, mon_irq_e[5], mon_irq_e[4:0]);
                end
            end
        end
    end

    // Advance one clock; single-cycle strobes drop after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        we      = 1'b0;
        irq_ack = 1'b0;
        rd_req  = 1'b0;
        chk_irq = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        w_addr = a;
        w_data = d;
        we     = 1'b1;
    endtask

    // Read returns the register contents visible in the current cycle.
    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        r_addr = a;
        rd_req = 1'b1;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(nm);
    endtask

    // Expected irq/irq_id in the current cycle.
    task automatic chk(input logic e_irq, input logic [4:0] e_id, input string nm);
        chk_irq = 1'b1;
        irq_exp_q.push_back({e_irq, e_id});
        irq_name_q.push_back(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset and register defaults ----------------
        tick();
        chk(1'b0, 5'd0, "rst_hold0");
        tick();
        chk(1'b0, 5'd0, "rst_hold1");
        tick();
        rst = 1'b0;
        rd(A_PEND, 32'h0, "rst_pending"); chk(1'b0, 5'd0, "rst_irq0"); tick();
        rd(A_MASK, 32'h0, "rst_mask");    chk(1'b0, 5'd0, "rst_irq1"); tick();
        rd(A_MODE, 32'h0, "rst_mode");    chk(1'b0, 5'd0, "rst_irq2"); tick();
        rd(A_ACT,  32'h0, "rst_active");  chk(1'b0, 5'd0, "rst_irq3"); tick();
        rd(A_EOI,  32'h0, "rst_eoi_rd");  tick();

        // ---------------- edge mode, channel 0 ----------------
        wr(A_MODE, 32'h1); tick();
        wr(A_MASK, 32'h1); tick();
        irq_in[0] = 1'b1;
        tick();                                  // edge 0
        irq_in[0] = 1'b0;
        chk(1'b0, 5'd0, "edge_lat_e0"); tick();
        chk(1'b0, 5'd0, "edge_lat_e1"); tick();
        chk(1'b0, 5'd0, "edge_lat_e2");
        rd(A_PEND, 32'h1, "edge_pending_set"); tick();
        chk(1'b1, 5'd0, "edge_lat_e3");
        irq_ack = 1'b1; tick();
        chk(1'b0, 5'd0, "edge_ack_drop");
        rd(A_PEND, 32'h0, "edge_ack_clr"); tick();
        rd(A_ACT, 32'h8000_0000, "edge_active"); tick();
        wr(A_EOI, 32'h0);
        rd(A_ACT, 32'h8000_0000, "eoi_same_cycle_old"); tick();
        rd(A_ACT, 32'h0, "eoi_active_clr");
        chk(1'b0, 5'd0, "eoi_idle"); tick();

        // ---------------- register window edges ----------------
        wr(A_MODE, 32'h0); tick();
        wr(A_MASK, 32'hFFFF_FFFF); tick();
        wr(32'h0000_0004, 32'h0); tick();        // outside window: ignored
        rd(A_MASK, 32'h0000_00FF, "mask_width"); tick();
        rd(32'h0000_0004, 32'h0, "out_of_window"); tick();
        rd(BASE + 32'h14, 32'h0, "unmapped_off"); tick();

        // ---------------- priority, level mode ----------------
        irq_in = 8'h24;
        ticks(3);
        chk(1'b0, 5'd0, "prio_pre"); tick();
        chk(1'b1, 5'd2, "prio_lowest");
        irq_ack = 1'b1; tick();
        chk(1'b0, 5'd2, "prio_svc");
        rd(A_ACT, 32'h8000_0002, "prio_active"); tick();
        wr(A_EOI, 32'h0); tick();
        chk(1'b0, 5'd2, "prio_eoi_idle"); tick();
        chk(1'b1, 5'd2, "prio_rereq");
        irq_ack = 1'b1; tick();
        irq_in = 8'h20;
        ticks(3);
        rd(A_PEND, 32'h20, "prio_level_follow"); tick();
        wr(A_EOI, 32'h0); tick();
        tick();
        chk(1'b1, 5'd5, "prio_next");
        irq_ack = 1'b1; tick();
        irq_in = 8'h00;
        ticks(3);
        wr(A_EOI, 32'h0); tick();
        tick();
        chk(1'b0, 5'd5, "prio_quiet");

        // ---------------- retraction ----------------
        wr(A_MASK, 32'h08); tick();
        irq_in = 8'h08;
        ticks(4);
        chk(1'b1, 5'd3, "retr_req");
        wr(A_MASK, 32'h0); tick();
        chk(1'b1, 5'd3, "retr_hold"); tick();
        chk(1'b0, 5'd3, "retr_drop");
        rd(A_ACT, 32'h0, "retr_active"); tick();
        wr(A_MASK, 32'h08); tick();
        tick();
        chk(1'b1, 5'd3, "retr2_req");
        wr(A_MASK, 32'h0); tick();
        chk(1'b1, 5'd3, "retr2_hold");
        irq_ack = 1'b1; tick();                  // ack collides with retraction
        chk(1'b0, 5'd3, "retr_ack_wins");
        rd(A_ACT, 32'h8000_0003, "retr_ack_active"); tick();
        irq_in = 8'h00;
        wr(A_EOI, 32'h0); tick();

        // ---------------- edge collisions, channel 1 ----------------
        wr(A_MODE, 32'h02); tick();
        irq_in = 8'h02;
        tick();                                  // edge 0
        tick();                                  // edge 1
        wr(A_PEND, 32'h02); tick();              // edge 2: set and W1C
        rd(A_PEND, 32'h02, "w1c_set_wins"); tick();
        wr(A_PEND, 32'h02); tick();
        rd(A_PEND, 32'h0, "w1c_clear"); tick();
        irq_in = 8'h00;
        ticks(3);
        irq_in = 8'h02;
        tick();                                  // e0
        wr(A_MASK, 32'h02); tick();              // e1
        tick();                                  // e2: pending
        tick();                                  // e3: request
        chk(1'b1, 5'd1, "coll_req");
        irq_in = 8'h00; tick();                  // e4
        irq_in = 8'h02; tick();                  // e5
        tick();                                  // e6
        chk(1'b1, 5'd1, "coll_pre_ack");
        irq_ack = 1'b1; tick();                  // e7: ack with new edge
        chk(1'b0, 5'd1, "coll_svc");
        rd(A_PEND, 32'h02, "ack_edge_keep"); tick();

        // ---------------- reset mid-SERVICE ----------------
        wr(A_EOI, 32'h0); tick();
        tick();
        chk(1'b1, 5'd1, "pre_rst_req");
        irq_ack = 1'b1; tick();
        chk(1'b0, 5'd1, "pre_rst_svc");
        rd(A_ACT, 32'h8000_0001, "pre_rst_active"); tick();
        rst    = 1'b1;
        irq_in = 8'hFF;
        tick();
        rst = 1'b0;
        chk(1'b0, 5'd0, "rst_mid_irq");
        rd(A_ACT, 32'h0, "rst_mid_active"); tick();
        ticks(2);
        rd(A_PEND, 32'h0000_00FF, "rst_level_pending");
        chk(1'b0, 5'd0, "rst_masked"); tick();
        tick();
        chk(1'b0, 5'd0, "rst_masked_late"); tick();

        // ---------------- drain ----------------
        ticks(3);
        n_tests++;
        if (rd_exp_q.size() != 0 || irq_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d reads and %0d irq checks left, expected 0 and 0",
                     rd_exp_q.size(), irq_exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller that drives the fetch stage's `irq` input, which the current pipeline ties low. It synchronises up to 32 external interrupt lines and latches them per channel in edge or level mode. Lines are masked, the lowest-numbered enabled channel wins, and the request is held to the pipeline under a request/acknowledge/end-of-interrupt handshake. Software controls it through a small register window on the data-memory bus.

## Interface

- NUM_IRQ, 8, number of interrupt channels (1..32)
- SYNC_STAGES, 2, synchroniser depth on `irq_in` (>=2)
- BASE_ADDR, 32'hFFFF_0000, register window base; window is 32 bytes, aligned to 32

- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- irq_in  in  NUM_IRQ  asynchronous interrupt lines
- irq  out  1  interrupt request to the fetch stage
- irq_id  out  5  channel number of the current request / in-service channel
- irq_ack  in  1  one-cycle pulse from the fetch stage when it takes the trap
- w_addr  in  32  register write address (byte)
- w_data  in  32  register write data
- we  in  1  register write enable
- r_addr  in  32  register read address (byte)
- r_data  out  32  register read data, registered

## Operation

- Register map (offsets from BASE_ADDR):
  - 0x00 PENDING: read; write-1-to-clear, effective on edge-mode bits only.
  - 0x04 MASK: RW; 1 = enabled.
  - 0x08 MODE: RW; 1 = edge, 0 = level.
  - 0x0C ACTIVE: read only; bit 31 = in-service valid, [4:0] = in-service id.
  - 0x10 EOI: write, any data.
- Bits at or above NUM_IRQ read 0 and ignore writes. Unmapped offsets and addresses outside the window read 0; writes to them are ignored.
- Synchroniser: SYNC_STAGES flops per line.
- Edge mode: a rising edge of the synchronised line (sync high, previous sync low) sets PENDING.
- Level mode: PENDING follows the synchronised line each cycle.
- enabled = PENDING & MASK. Selected channel = lowest index set in `enabled`.
- State machine:
  - IDLE: `irq`=0. If `enabled` != 0, latch the selected id into `irq_id`, go to REQ.
  - REQ: `irq`=1 and `irq_id` frozen.
    - On `irq_ack`: clear PENDING[id] if the channel is edge mode, set in-service, go to SERVICE.
    - Else, if the latched channel's `enabled` bit is 0: go to IDLE (retraction).
  - SERVICE: `irq`=0; `irq_id` holds the in-service id. EOI write goes to IDLE and clears in-service.
- No nesting. Requests arriving during SERVICE stay pending.
- Simultaneous events:
  - Edge set and W1C on the same bit in the same cycle: set wins.
  - `irq_ack` and a new edge on the same channel in the same cycle: PENDING stays 1.
  - `irq_ack` and retraction in the same cycle: ack wins.
  - EOI in IDLE or REQ: ignored.
  - `irq_ack` outside REQ: ignored.
  - Write and read to the same register in the same cycle: `r_data` returns the old value.
- Reset: state IDLE; PENDING, MASK, MODE, in-service, sync flops, `irq`, `irq_id` and `r_data` all cleared to 0. Reset mid-REQ or mid-SERVICE drops `irq` on the next edge and discards the in-service state.

## Timing

- `irq_in` rises before clock edge 0.
  - The synchronised value is high after edge SYNC_STAGES-1.
  - PENDING is set at edge SYNC_STAGES.
  - `irq` is high after edge SYNC_STAGES+1.
  - Total latency is SYNC_STAGES+2 cycles (4 at the default).
- `irq` and `irq_id` are registered outputs.
- `irq_ack` sampled at edge n: `irq` is 0 after edge n.
- Retraction: MASK cleared at edge n puts `irq` at 0 after edge n+1.
- EOI write at edge n: state IDLE after n. With `enabled` still nonzero, `irq`=1 again after n+1.
- Register read: `r_addr` sampled at edge n, `r_data` valid after edge n (1-cycle latency).
- MASK/MODE writes take effect at the edge they are sampled.

## Test plan

- Reset, then read all registers -> every read returns 0; `irq`=0 and `irq_id`=0 throughout.
- Edge mode: MODE=0x01, MASK=0x01, pulse `irq_in[0]` for 1 cycle.
  - Expected: `irq`=1 exactly 4 cycles after the rising edge, `irq_id`=0.
  - `irq_ack` drops `irq` the next cycle and clears PENDING[0]; ACTIVE reads 0x8000_0000.
  - EOI write -> ACTIVE reads 0.
- Priority: MASK=0xFF, level mode, raise lines 5 and 2 in the same cycle.
  - Expected: `irq_id`=2. After ack and EOI with line 2 still high, the request is again id 2.
  - Drop line 2, then EOI -> next request is id 5.
- Retraction: assert line 3 in level mode with MASK=0x08 until `irq`=1, then write MASK=0 -> `irq`=0 one cycle later and state returns to IDLE.
  - Repeat with `irq_ack` in the same cycle as the MASK write -> SERVICE is entered with in-service id 3.
- Collisions, edge mode on channel 1:
  - Rising edge arrives in the same cycle as a W1C of bit 1 -> PENDING[1] stays 1.
  - Second edge arrives in the same cycle as `irq_ack` -> PENDING[1]=1 after ack.
- Reset mid-SERVICE: assert `rst` -> after one edge `irq`=0 and ACTIVE reads 0. With `irq_in` held high and MODE=0 after reset, `irq` stays 0 because MASK=0.
